// File: rtl/state_machine_driver.sv
// Transmit-side driver for the 8-state pulse FSM's b[3:1] interface.
// Drives a cycle-exact button sequence per command and checks the consumer's outp.
module state_machine_driver #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_src,
  input  logic             cmd_long,
  input  logic             cmd_ext,
  output logic [3:1]       b,
  output logic             busy,
  output logic             done,
  output logic             exp_outp,
  input  logic             outp_in,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [2:0] {StIdle, StStart, StGap, StMark, StExt, StHold} state_e;

  state_e           state_q, state_d;
  logic             src_q, src_d;
  logic             long_q, long_d;
  logic             ext_q, ext_d;
  logic [1:0]       hc_q, hc_d;
  logic [3:1]       b_q, b_d;
  logic             mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_q, err_d;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    long_d   = long_q;
    ext_d    = ext_q;
    hc_d     = hc_q;
    done     = 1'b0;
    exp_outp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          src_d   = cmd_src;
          long_d  = cmd_long;
          ext_d   = cmd_ext;
          state_d = StStart;
        end
      end
      StStart: state_d = StGap;
      StGap:   state_d = StMark;
      StMark: begin
        exp_outp = long_q;
        state_d  = StExt;
      end
      StExt: begin
        exp_outp = 1'b1;
        if (ext_q) begin
          state_d = StHold;
          hc_d    = 2'd0;
        end else begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      StHold: begin
        hc_d = hc_q + 2'd1;
        if (hc_q == 2'd3) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // b is registered from the next state so it lines up with the state it belongs to.
  always_comb begin
    b_d = 3'b000;
    case (state_d)
      StStart: b_d = {1'b0, src_d, ~src_d};
      StMark:  b_d = {long_d, long_d & src_d, long_d & ~src_d};
      StExt:   b_d = {1'b0, ext_d, 1'b0};
      default: b_d = 3'b000;
    endcase
  end

  always_comb begin
    mismatch_d = mismatch_q;
    err_d      = err_q;
    if (outp_in != exp_outp) begin
      mismatch_d = 1'b1;
      if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      src_q      <= 1'b0;
      long_q     <= 1'b0;
      ext_q      <= 1'b0;
      hc_q       <= 2'd0;
      b_q        <= 3'b000;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      long_q     <= long_d;
      ext_q      <= ext_d;
      hc_q       <= hc_d;
      b_q        <= b_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign b         = b_q;
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_state_machine_driver.sv
// Scoreboard bench for state_machine_driver with a behavioural pulse-FSM consumer.
module tb_state_machine_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_src = 1'b0, cmd_long = 1'b0, cmd_ext = 1'b0;
  logic       cmd_ready, busy, done, exp_outp, mismatch, outp_in;
  logic [3:1] b;
  logic [1:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;
  int mode  = 0;  // 0: consumer model, 1: force 1, 2: ~exp_outp

  logic [4:0] exp_q[$];  // {b[3:1], exp_outp, done}

  always #5 clk = ~clk;

  state_machine_driver #(.ERR_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_src  (cmd_src),
    .cmd_long (cmd_long),
    .cmd_ext  (cmd_ext),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .exp_outp (exp_outp),
    .outp_in  (outp_in),
    .mismatch (mismatch),
    .err_cnt  (err_cnt)
  );

  // Independent model of the consumer: S0 waits for b1|b2, S2 outputs b3, S3 outputs 1.
  logic [2:0] cs;
  logic       cons_outp;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cs <= 3'd0;
    else begin
      case (cs)
        3'd0:    cs <= (b[1] | b[2]) ? 3'd1 : 3'd0;
        3'd3:    cs <= b[2] ? 3'd4 : 3'd0;
        3'd7:    cs <= 3'd0;
        default: cs <= cs + 3'd1;
      endcase
    end
  end
  assign cons_outp = (cs == 3'd2) ? b[3] : (cs == 3'd3);
  assign outp_in   = (mode == 1) ? 1'b1 : (mode == 2) ? ~exp_outp : cons_outp;

  always @(negedge clk) begin
    if (!rst && busy) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_busy: b=%b exp_outp=%b done=%b, required idle", b, exp_outp, done);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({b, exp_outp, done, cmd_ready} != {e, 1'b0}) begin
          n_err++;
          $display("FAIL seq: got b=%b exp_outp=%b done=%b ready=%b, required b=%b exp_outp=%b done=%b ready=0",
                   b, exp_outp, done, cmd_ready, e[4:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_cmd(input logic s, input logic l, input logic e);
    exp_q.push_back({1'b0, s, ~s, 1'b0, 1'b0});
    exp_q.push_back(5'b000_0_0);
    exp_q.push_back({l, l & s, l & ~s, l, 1'b0});
    exp_q.push_back({1'b0, e, 1'b0, 1'b1, ~e});
    if (e) for (int i = 0; i < 4; i++) exp_q.push_back({3'b000, 1'b0, (i == 3)});
  endtask

  task automatic drain(input bit scramble);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      if (scramble) begin
        cmd_valid = 1'($urandom);
        cmd_src   = 1'($urandom);
        cmd_long  = 1'($urandom);
        cmd_ext   = 1'($urandom);
      end
      @(negedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 8'(exp_q.size()), 8'd0);
      exp_q.delete();
    end
  endtask

  task automatic run_cmd(input logic s, input logic l, input logic e, input bit scramble);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_src = s; cmd_long = l; cmd_ext = e;
    push_cmd(s, l, e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    drain(scramble);
    @(posedge clk); #1;
    chk("mismatch_after_cmd", 8'(mismatch), 8'd0);
  endtask

  initial begin
    int idle_cnt, dones;
    bit seen;
    @(negedge clk);
    chk("rst_b", 8'(b), 8'd0);
    chk("rst_ready", 8'(cmd_ready), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_exp_outp", 8'(exp_outp), 8'd0);
    chk("rst_mismatch", 8'(mismatch), 8'd0);
    chk("rst_err_cnt", 8'(err_cnt), 8'd0);
    rst = 1'b0;

    run_cmd(1'b0, 1'b0, 1'b0, 1'b0);
    run_cmd(1'b1, 1'b1, 1'b1, 1'b0);
    run_cmd(1'b0, 1'b1, 1'b1, 1'b1);  // fields scrambled after accept
    run_cmd(1'b1, 1'b0, 1'b0, 1'b1);

    // Back-to-back with cmd_valid held.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_src = 1'b0; cmd_long = 1'b1; cmd_ext = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 1'b1, 1'b0);
    idle_cnt = 0; dones = 0; seen = 1'b0;
    for (int i = 0; i < 60 && dones < 3; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      if (seen && !busy) begin
        idle_cnt++;
        chk("b2b_idle_ready", 8'(cmd_ready), 8'd1);
      end
      if (done) dones++;
    end
    cmd_valid = 1'b0;
    chk("b2b_dones", 8'(dones), 8'd3);
    chk("b2b_idle_cycles", 8'(idle_cnt), 8'd2);
    @(posedge clk); #1;
    chk("b2b_mismatch", 8'(mismatch), 8'd0);
    chk("b2b_queue_left", 8'(exp_q.size()), 8'd0);

    // Forced mismatches in IDLE, counter saturating at 3.
    mode = 1;
    @(negedge clk);
    chk("mm_not_yet", 8'(mismatch), 8'd0);
    @(posedge clk); #1;
    mode = 0;
    chk("mm_set", 8'(mismatch), 8'd1);
    chk("mm_cnt1", 8'(err_cnt), 8'd1);
    mode = 2;
    repeat (4) @(posedge clk);
    #1;
    mode = 0;
    chk("mm_cnt_sat", 8'(err_cnt), 8'd3);
    @(posedge clk); #1;
    chk("mm_sticky", 8'(mismatch), 8'd1);

    // Reset during MARK.
    cmd_valid = 1'b1; cmd_src = 1'b1; cmd_long = 1'b1; cmd_ext = 1'b0;
    push_cmd(1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mark_b", 8'(b), 8'b110);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_b", 8'(b), 8'd0);
    chk("midrst_busy", 8'(busy), 8'd0);
    chk("midrst_done", 8'(done), 8'd0);
    chk("midrst_mismatch", 8'(mismatch), 8'd0);
    chk("midrst_err_cnt", 8'(err_cnt), 8'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    run_cmd(1'b0, 1'b1, 1'b1, 1'b0);
    chk("final_err_cnt", 8'(err_cnt), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/state_machine_driver.md
# state_machine_driver

Stimulus driver and checker that plays the transmit side of the `b[3:1]` button interface consumed by the 8-state pulse FSM. It accepts one command per handshake and drives a cycle-exact `b` sequence that walks the consumer through its start, mark, and optional extend/hold phases. It also predicts the consumer's `outp` each cycle, compares it against the returned `outp`, and records mismatches. It sits beside the consumer in the same clock and reset domain, and both must be reset together.

## Interface
- `ERR_W`, default 8: width of the saturating mismatch counter.
- `clk` in 1: rising-edge clock shared with the consumer.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: driver can accept a command; high only in IDLE.
- `cmd_src` in 1: start line select; 0 selects `b[1]`, 1 selects `b[2]`.
- `cmd_long` in 1: request `outp` high in the consumer's S2 phase.
- `cmd_ext` in 1: request the S3 to S4–S7 hold-off path.
- `b` out 3 (`[3:1]`): registered drive to the consumer.
- `busy` out 1: command in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse in the last driven cycle of a command.
- `exp_outp` out 1: predicted consumer `outp` for the current cycle.
- `outp_in` in 1: actual consumer `outp`.
- `mismatch` out 1: sticky; set on any compare failure.
- `err_cnt` out `ERR_W`: count of compare failures; saturates at 2^ERR_W−1.

## Operation
- States: IDLE, START, GAP, MARK, EXT, HOLD. HOLD uses a 2-bit counter `hc`.
- IDLE: `b`=000, `cmd_ready`=1. When `cmd_valid&cmd_ready`, latch `src`/`long`/`ext` and go to START.
- START: drive `b[1]`=~src and `b[2]`=src, with `b[3]`=0. This lines up with consumer S0, which moves to S1. Next state is GAP.
- GAP: `b`=000 (consumer in S1). Next state is MARK.
- MARK: consumer in S2. `b[3]`=long, `b[1]`=long&~src, `b[2]`=long&src. Next state is EXT.
- EXT: consumer in S3. `b[2]`=ext, with `b[1]`=`b[3]`=0.
  - If ext: go to HOLD with `hc`=0.
  - Otherwise: go to IDLE and assert `done`.
- HOLD: `b`=000 for 4 cycles (consumer in S4–S7). `hc` increments each cycle. At `hc`=3, assert `done` and go to IDLE.
- `exp_outp` is combinational from registered state:
  - MARK: equals `long`.
  - EXT: 1.
  - All other states: 0.
- Checker runs every cycle out of reset, IDLE included. At each rising edge, if `outp_in`≠`exp_outp`:
  - set `mismatch`;
  - increment `err_cnt` unless it is at max.
- `cmd_valid` outside IDLE is ignored. Commands are never queued.
- Command fields are latched at accept, so later input changes have no effect.

## Timing
- Reset (async, immediate) sets: state=IDLE, `b`=000, `cmd_ready`=1, `busy`=0, `done`=0, `exp_outp`=0, `mismatch`=0, `err_cnt`=0, latched fields=0.
- Accept at edge k puts START in cycle k+1. MARK is cycle k+3 and EXT is cycle k+4.
- Command length:
  - non-ext: 4 cycles (START to EXT);
  - ext: 8 cycles (START to last HOLD).
- Back-to-back: IDLE lasts exactly one cycle between commands if `cmd_valid` is held. That IDLE cycle lines up with consumer S0, so the next START also lines up with S0.
- `done` is combinational, high in EXT when `ext`=0, or in HOLD when `hc`=3.
- `mismatch` and `err_cnt` update at the edge ending the failing cycle, so they are visible one cycle later.
- Reset mid-command: immediate return to IDLE. No `done` pulse is issued and the checker history is cleared.

## Test plan
- Reset, then accept src=0, long=0, ext=0 at edge 1:
  - `b` cycles 2–5 = 001, 000, 000, 000;
  - `exp_outp` = 0, 0, 0, 1;
  - `done` high in cycle 5;
  - with the real consumer attached, `mismatch`=0.
- Accept src=1, long=1, ext=1:
  - `b` = 010, 000, 110, 010, then 000 ×4;
  - `exp_outp` = 0, 0, 1, 1, 0, 0, 0, 0;
  - `done` on the 8th cycle;
  - `busy` high for 8 cycles.
- Hold `cmd_valid`=1 for three ext=0 commands: exactly one IDLE cycle between commands, zero mismatches, `cmd_ready` high only in those IDLE cycles.
- Force `outp_in`=1 in one IDLE cycle and for the full `outp_in`=~`exp_outp` case:
  - `mismatch` rises one cycle later and stays set;
  - with ERR_W=2, 5 failures leave `err_cnt`=3.
- Assert `rst` during MARK: `b`=000 and `busy`=0 immediately with no `done`. Release, then reissue a command: correct sequence and zero mismatches.
- Toggle `cmd_long`/`cmd_ext` during an active command: the `b` sequence follows the values latched at accept.
